// File: rtl/gate_sensor_decoder_pkg.sv
// Shared types for the door gate decoder: FSM state encoding, direction
// levels and the pure next-state/event decode of the crossing table.
package gate_sensor_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IN_A     = 3'd1,
    ST_IN_AB    = 3'd2,
    ST_IN_B     = 3'd3,
    ST_OUT_B    = 3'd4,
    ST_OUT_BA   = 3'd5,
    ST_OUT_A    = 3'd6,
    ST_WAIT_CLR = 3'd7
  } gate_state_e;

  localparam logic DIR_ENTRY = 1'b1;
  localparam logic DIR_EXIT  = 1'b0;
  localparam int   NUM_SENS  = 2;

  typedef struct packed {
    gate_state_e nxt;
    logic        evt;
    logic        dir;
  } gate_step_t;

  // ab = {filtered outer, filtered inner}; combinations not listed hold the state.
  function automatic gate_step_t decode_step(input gate_state_e s, input logic [1:0] ab);
    gate_step_t r;
    r.nxt = s;
    r.evt = 1'b0;
    r.dir = DIR_EXIT;
    case (s)
      ST_IDLE: case (ab)
        2'b10:   r.nxt = ST_IN_A;
        2'b01:   r.nxt = ST_OUT_B;
        2'b11:   r.nxt = ST_WAIT_CLR;
        default: ;
      endcase
      ST_IN_A: case (ab)
        2'b11:   r.nxt = ST_IN_AB;
        2'b01:   r.nxt = ST_IN_B;
        2'b00:   r.nxt = ST_IDLE;
        default: ;
      endcase
      ST_IN_AB: case (ab)
        2'b01:   r.nxt = ST_IN_B;
        2'b10:   r.nxt = ST_IN_A;
        2'b00:   r.nxt = ST_IDLE;
        default: ;
      endcase
      ST_IN_B: case (ab)
        2'b00: begin
          r.nxt = ST_IDLE;
          r.evt = 1'b1;
          r.dir = DIR_ENTRY;
        end
        2'b11:   r.nxt = ST_IN_AB;
        2'b10:   r.nxt = ST_IN_A;
        default: ;
      endcase
      ST_OUT_B: case (ab)
        2'b11:   r.nxt = ST_OUT_BA;
        2'b10:   r.nxt = ST_OUT_A;
        2'b00:   r.nxt = ST_IDLE;
        default: ;
      endcase
      ST_OUT_BA: case (ab)
        2'b10:   r.nxt = ST_OUT_A;
        2'b01:   r.nxt = ST_OUT_B;
        2'b00:   r.nxt = ST_IDLE;
        default: ;
      endcase
      ST_OUT_A: case (ab)
        2'b00: begin
          r.nxt = ST_IDLE;
          r.evt = 1'b1;
          r.dir = DIR_EXIT;
        end
        2'b11:   r.nxt = ST_OUT_BA;
        2'b01:   r.nxt = ST_OUT_B;
        default: ;
      endcase
      ST_WAIT_CLR: if (ab == 2'b00) r.nxt = ST_IDLE;
      default: r.nxt = ST_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_sensor_decoder_debounce.sv
// Synchroniser plus stable-count debouncer for one asynchronous beam sensor.
module sensor_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEB_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync;
  logic [DEB_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + DEB_W'(1);
    end
  end

endmodule

// File: rtl/gate_sensor_decoder.sv
// Two-beam door decoder: debounced sensors feed a crossing-order FSM that
// emits one-cycle entry/exit events, with a per-state timeout fault.
module gate_sensor_decoder
  import gate_sensor_decoder_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEB_W           = 3,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int TMO_W           = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic sens_a,
  input  logic sens_b,
  output logic evt_valid,
  output logic updown,
  output logic busy,
  output logic fault
);

  logic [NUM_SENS-1:0] raw;
  logic [NUM_SENS-1:0] filt;
  gate_state_e         state, state_nxt;
  gate_step_t          step;
  logic [TMO_W-1:0]    timer;
  logic                evt_nxt;
  logic                tmo_take;

  assign raw = {sens_a, sens_b};

  for (genvar i = 0; i < NUM_SENS; i++) begin : g_sens
    sensor_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DEB_W          (DEB_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .level(filt[i])
    );
  end

  // Timeout overrides the table, except that WAIT_CLR may still leave on 00.
  always_comb begin
    step      = decode_step(state, filt);
    state_nxt = step.nxt;
    evt_nxt   = step.evt;
    tmo_take  = 1'b0;
    if ((state != ST_IDLE) && (timer == TMO_W'(TIMEOUT_CYCLES - 1)) &&
        !((state == ST_WAIT_CLR) && (step.nxt == ST_IDLE))) begin
      tmo_take  = 1'b1;
      state_nxt = ST_WAIT_CLR;
      evt_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      evt_valid <= 1'b0;
      updown    <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      evt_valid <= evt_nxt;
      if (evt_nxt) updown <= step.dir;
      if (state_nxt == ST_IDLE) fault <= 1'b0;
      else if (tmo_take)        fault <= 1'b1;
      // Timer saturates once the timeout fires so WAIT_CLR keeps the fault asserted.
      if (tmo_take)                                        timer <= timer;
      else if ((state_nxt != state) || (state == ST_IDLE)) timer <= '0;
      else                                                 timer <= timer + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Self-checking bench for gate_sensor_decoder: directed scenarios plus
// randomized crossings scored against a behavioural crossing-table model.
module tb_gate_sensor_decoder;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB + 1;
  localparam int TMO  = 1000;

  localparam int M_IDLE = 0, M_IN_A = 1, M_IN_AB = 2, M_IN_B = 3;
  localparam int M_OUT_B = 4, M_OUT_BA = 5, M_OUT_A = 6, M_WAIT = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic evt_valid, updown, busy, fault;

  gate_sensor_decoder #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .DEB_W(3),
    .TIMEOUT_CYCLES(TMO), .TMO_W(10)
  ) dut (
    .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
    .evt_valid(evt_valid), .updown(updown), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic d; } ev_t;
  ev_t ev_q[$];
  ev_t exp_q[$];
  int  cyc = 0;
  int  busy_hi = 0;
  int  fault_rise = -1, fault_fall = -1;
  int  checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (evt_valid === 1'b1) ev_q.push_back('{c: cyc, d: updown});
    if (busy === 1'b1) busy_hi++;
    if (fault === 1'b1 && fault_rise < 0) fault_rise = cyc;
    if (fault === 1'b0 && fault_rise >= 0 && fault_fall < 0) fault_fall = cyc;
  end

  task automatic drive(input logic a, input logic b, input int n);
    sens_a = a;
    sens_b = b;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Crossing table straight from the behavioural rules.
  function automatic void m_step(input int s, input logic [1:0] ab,
                                 output int ns, output bit ev, output logic dir);
    ns = s; ev = 0; dir = 1'b0;
    case (s)
      M_IDLE:   ns = (ab == 2'b10) ? M_IN_A : (ab == 2'b01) ? M_OUT_B : (ab == 2'b11) ? M_WAIT : s;
      M_IN_A:   ns = (ab == 2'b11) ? M_IN_AB : (ab == 2'b01) ? M_IN_B : (ab == 2'b00) ? M_IDLE : s;
      M_IN_AB:  ns = (ab == 2'b01) ? M_IN_B : (ab == 2'b10) ? M_IN_A : (ab == 2'b00) ? M_IDLE : s;
      M_IN_B: begin
        ns = (ab == 2'b00) ? M_IDLE : (ab == 2'b11) ? M_IN_AB : (ab == 2'b10) ? M_IN_A : s;
        if (ab == 2'b00) begin ev = 1; dir = 1'b1; end
      end
      M_OUT_B:  ns = (ab == 2'b11) ? M_OUT_BA : (ab == 2'b10) ? M_OUT_A : (ab == 2'b00) ? M_IDLE : s;
      M_OUT_BA: ns = (ab == 2'b10) ? M_OUT_A : (ab == 2'b01) ? M_OUT_B : (ab == 2'b00) ? M_IDLE : s;
      M_OUT_A: begin
        ns = (ab == 2'b00) ? M_IDLE : (ab == 2'b11) ? M_OUT_BA : (ab == 2'b01) ? M_OUT_B : s;
        if (ab == 2'b00) begin ev = 1; dir = 1'b0; end
      end
      default:  ns = (ab == 2'b00) ? M_IDLE : s;
    endcase
  endfunction

  task automatic test_reset;
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_evt got=%b exp=0", evt_valid); end
    checks++; if (updown !== 1'b0) begin failures++; $display("FAIL rst_updown got=%b exp=0", updown); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", fault); end
    reset = 1'b0;
    drive(0, 0, 10);
    checks++; if (busy !== 1'b0 || ev_q.size() != 0) begin
      failures++; $display("FAIL rst_idle busy=%b events=%0d exp busy=0 events=0", busy, ev_q.size());
    end
  endtask

  task automatic test_entry;
    int tf;
    ev_q.delete();
    drive(1, 0, 20);
    drive(1, 1, 20);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL entry_busy got=%b exp=1", busy); end
    drive(0, 1, 20);
    tf = cyc;
    drive(0, 0, 20);
    checks++; if (ev_q.size() != 1) begin
      failures++; $display("FAIL entry_count got=%0d exp=1", ev_q.size());
    end else begin
      checks++; if (ev_q[0].d !== 1'b1) begin failures++; $display("FAIL entry_dir got=%b exp=1", ev_q[0].d); end
      checks++; if (ev_q[0].c != tf + LAT) begin
        failures++; $display("FAIL entry_latency got=%0d exp=%0d", ev_q[0].c - tf, LAT);
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL entry_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_abort;
    ev_q.delete();
    drive(1, 0, 20);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busy); end
    drive(0, 0, 20);
    checks++; if (ev_q.size() != 0) begin failures++; $display("FAIL abort_noevt got=%0d exp=0", ev_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busyfall got=%b exp=0", busy); end
    checks++; if (updown !== 1'b1) begin failures++; $display("FAIL abort_updown got=%b exp=1", updown); end
  endtask

  task automatic test_exit;
    int t0, tf;
    ev_q.delete();
    busy_hi = 0;
    t0 = cyc;
    drive(0, 1, 20);
    drive(1, 1, 20);
    drive(1, 0, 20);
    tf = cyc;
    drive(0, 0, 20);
    checks++; if (ev_q.size() != 1) begin
      failures++; $display("FAIL exit_count got=%0d exp=1", ev_q.size());
    end else begin
      checks++; if (ev_q[0].d !== 1'b0) begin failures++; $display("FAIL exit_dir got=%b exp=0", ev_q[0].d); end
      checks++; if (ev_q[0].c != tf + LAT) begin
        failures++; $display("FAIL exit_latency got=%0d exp=%0d", ev_q[0].c - tf, LAT);
      end
    end
    checks++; if (busy_hi != tf - t0) begin
      failures++; $display("FAIL exit_busy_cycles got=%0d exp=%0d", busy_hi, tf - t0);
    end
  endtask

  task automatic test_glitch;
    ev_q.delete();
    busy_hi = 0;
    drive(1, 0, 3);
    drive(0, 0, 10);
    drive(1, 1, 1);
    drive(0, 0, 10);
    drive(0, 1, 1);
    drive(0, 0, 3);
    drive(0, 1, 3);
    drive(0, 0, 12);
    checks++; if (busy_hi != 0) begin failures++; $display("FAIL glitch_busy got=%0d exp=0", busy_hi); end
    checks++; if (ev_q.size() != 0) begin failures++; $display("FAIL glitch_noevt got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_random;
    int st, ns, n, len, tmpl;
    bit ev;
    logic dir, m_ud;
    logic [1:0] v;
    logic [1:0] seq_in [4];
    logic [1:0] seq_out [4];
    seq_in  = '{2'b10, 2'b11, 2'b01, 2'b00};
    seq_out = '{2'b01, 2'b11, 2'b10, 2'b00};
    m_ud = updown;
    for (int run = 0; run < 8; run++) begin
      ev_q.delete();
      exp_q.delete();
      st = M_IDLE;
      tmpl = $urandom_range(0, 2);
      n = (tmpl == 0) ? $urandom_range(4, 12) : 4;
      for (int k = 0; k <= n; k++) begin
        if (k == n)         v = 2'b00;
        else if (tmpl == 1) v = seq_in[k];
        else if (tmpl == 2) v = seq_out[k];
        else                v = 2'($urandom_range(0, 3));
        len = (k == n) ? 20 : $urandom_range(DEB + 4, 30);
        m_step(st, v, ns, ev, dir);
        st = ns;
        if (ev) begin exp_q.push_back('{c: cyc + LAT, d: dir}); m_ud = dir; end
        drive(v[1], v[0], len);
      end
      checks++; if (ev_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand_count run=%0d got=%0d exp=%0d", run, ev_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++; if (ev_q[i].c != exp_q[i].c || ev_q[i].d !== exp_q[i].d) begin
            failures++;
            $display("FAIL rand_evt run=%0d i=%0d got cyc=%0d dir=%b exp cyc=%0d dir=%b",
                     run, i, ev_q[i].c, ev_q[i].d, exp_q[i].c, exp_q[i].d);
          end
        end
      end
      checks++; if (updown !== m_ud || busy !== 1'b0) begin
        failures++; $display("FAIL rand_final run=%0d updown=%b busy=%b exp updown=%b busy=0", run, updown, busy, m_ud);
      end
    end
  endtask

  task automatic test_timeout;
    int tr, tl;
    ev_q.delete();
    fault_rise = -1;
    fault_fall = -1;
    tr = cyc;
    drive(1, 0, 1100);
    checks++; if (fault !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL tmo_fault fault=%b busy=%b exp fault=1 busy=1", fault, busy);
    end
    checks++; if (fault_rise < tr + LAT + TMO - 8 || fault_rise > tr + LAT + TMO + 2) begin
      failures++; $display("FAIL tmo_when got=%0d exp~=%0d", fault_rise - tr, LAT + TMO);
    end
    tl = cyc;
    drive(0, 0, 20);
    checks++; if (fault !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL tmo_clear fault=%b busy=%b exp 0 0", fault, busy);
    end
    checks++; if (fault_fall != tl + LAT) begin
      failures++; $display("FAIL tmo_fall got=%0d exp=%0d", fault_fall - tl, LAT);
    end
    checks++; if (ev_q.size() != 0) begin failures++; $display("FAIL tmo_noevt got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_reset_mid;
    drive(1, 0, 20);
    drive(1, 1, 10);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_pre busy=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({evt_valid, updown, busy, fault} !== 4'b0000) begin
      failures++; $display("FAIL rmid_outs got=%b exp=0000", {evt_valid, updown, busy, fault});
    end
    sens_a = 1'b0;
    sens_b = 1'b0;
    repeat (3) @(negedge clk);
    ev_q.delete();
    busy_hi = 0;
    reset = 1'b0;
    drive(0, 0, 20);
    checks++; if (ev_q.size() != 0 || busy_hi != 0) begin
      failures++; $display("FAIL rmid_after events=%0d busy_cycles=%0d exp 0 0", ev_q.size(), busy_hi);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_entry();
    test_abort();
    test_exit();
    test_glitch();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
